// File: rtl/regfile_read_mux.sv
// 32-entry register file written through a one-hot word-enable vector,
// with two registered read ports and same-edge write forwarding.
module regfile_read_mux #(
  parameter int WIDTH    = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      wr_onehot,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  input  logic [4:0]       rd_addr_a,
  input  logic [4:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid,
  output logic             wr_err
);

  logic [WIDTH-1:0] r_mem [32];
  logic [WIDTH-1:0] r_rd_data_a;
  logic [WIDTH-1:0] r_rd_data_b;
  logic             r_rd_valid;
  logic             r_wr_err;

  logic             w_wr_none;
  logic             w_wr_single;
  logic             w_wr_multi;
  logic [4:0]       w_wr_idx;
  logic             w_wr_en;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  // A vector is single-hot when clearing its lowest set bit leaves nothing.
  assign w_wr_none   = (wr_onehot == 32'd0);
  assign w_wr_single = !w_wr_none && ((wr_onehot & (wr_onehot - 32'd1)) == 32'd0);
  assign w_wr_multi  = !w_wr_none && !w_wr_single;

  always_comb begin
    w_wr_idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (wr_onehot[i]) w_wr_idx = 5'(i);
    end
  end

  assign w_wr_en = w_wr_single && !(ZERO_REG && (w_wr_idx == 5'd0));

  // Forwarding only ever sees a committed single-hot write; the zero register wins last.
  always_comb begin
    w_rd_a = r_mem[rd_addr_a];
    if (w_wr_en && (w_wr_idx == rd_addr_a)) w_rd_a = wr_data;
    if (ZERO_REG && (rd_addr_a == 5'd0))    w_rd_a = '0;

    w_rd_b = r_mem[rd_addr_b];
    if (w_wr_en && (w_wr_idx == rd_addr_b)) w_rd_b = wr_data;
    if (ZERO_REG && (rd_addr_b == 5'd0))    w_rd_b = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[w_wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data_a <= '0;
      r_rd_data_b <= '0;
      r_rd_valid  <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) begin
        r_rd_data_a <= w_rd_a;
        r_rd_data_b <= w_rd_b;
      end
      if (w_wr_multi) r_wr_err <= 1'b1;
    end
  end

  assign rd_data_a = r_rd_data_a;
  assign rd_data_b = r_rd_data_b;
  assign rd_valid  = r_rd_valid;
  assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_regfile_read_mux.sv
// Scoreboard bench for regfile_read_mux: directed stimulus pushes expected
// read pairs, a monitor pops and compares whenever rd_valid is seen.
module tb_regfile_read_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wr_onehot;
  logic [31:0] wr_data;
  logic        rd_req;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        rd_valid;
  logic        wr_err;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  regfile_read_mux #(.WIDTH(32), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .wr_onehot(wr_onehot), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid),
    .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Called just after a negedge; drives one cycle and returns at the next negedge.
  task automatic step(input logic [31:0] oh, input logic [31:0] d, input logic req,
                      input logic [4:0] a, input logic [4:0] b,
                      input logic [31:0] ea, input logic [31:0] eb);
    wr_onehot = oh;
    wr_data   = d;
    rd_req    = req;
    rd_addr_a = a;
    rd_addr_b = b;
    if (req) exp_q.push_back({ea, eb});
    @(negedge clk);
    wr_onehot = '0;
    rd_req    = 1'b0;
  endtask

  // Monitor
  initial begin
    logic [63:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got rd_valid=1 expected no pending read");
        end else begin
          e = exp_q.pop_front();
          check("rd_data_a", rd_data_a, e[63:32]);
          check("rd_data_b", rd_data_b, e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_onehot = '0; wr_data = '0; rd_req = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_rd_data_a", rd_data_a, 32'h0);
    check("reset_rd_data_b", rd_data_b, 32'h0);
    check("reset_rd_valid", {31'd0, rd_valid}, 32'h0);
    check("reset_wr_err", {31'd0, wr_err}, 32'h0);

    step(32'h0, 32'h0, 1'b1, 5'd5, 5'd31, 32'h0, 32'h0);

    // Ordinary write then read; zero register ignores writes.
    step(32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    step(32'h0, 32'h0, 1'b1, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0);
    step(32'h0000_0001, 32'h0000_1234, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    step(32'h0, 32'h0, 1'b1, 5'd0, 5'd5, 32'h0, 32'hDEAD_BEEF);

    // Same-edge forwarding to both ports.
    step(32'h0000_0400, 32'hA5A5_A5A5, 1'b1, 5'd10, 5'd10, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    step(32'h0, 32'h0, 1'b1, 5'd10, 5'd5, 32'hA5A5_A5A5, 32'hDEAD_BEEF);
    check("wr_err_clean", {31'd0, wr_err}, 32'h0);

    // Multi-hot: dropped, not forwarded, sticky error.
    step(32'h0000_0008, 32'h0000_0003, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    step(32'h0000_0009, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    check("wr_err_set", {31'd0, wr_err}, 32'h1);
    step(32'h0, 32'h0, 1'b1, 5'd3, 5'd0, 32'h0000_0003, 32'h0);
    step(32'h0000_0009, 32'hFFFF_FFFF, 1'b1, 5'd3, 5'd3, 32'h0000_0003, 32'h0000_0003);
    for (int i = 0; i < 10; i++)
      step(32'h1 << (11 + i), 32'(i + 100), 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    check("wr_err_sticky", {31'd0, wr_err}, 32'h1);
    step(32'h0, 32'h0, 1'b1, 5'd11, 5'd20, 32'd100, 32'd109);

    // Hold: outputs keep last read while rd_req is low.
    step(32'h0, 32'h0, 1'b1, 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      step(32'h0000_0020, 32'h1, 1'b0, 5'd7, 5'd7, 32'h0, 32'h0);
      check("hold_rd_valid", {31'd0, rd_valid}, 32'h0);
      check("hold_rd_data_a", rd_data_a, 32'hDEAD_BEEF);
    end
    step(32'h0, 32'h0, 1'b1, 5'd5, 5'd3, 32'h1, 32'h3);

    // Write to register 0 is neither stored nor forwarded.
    step(32'h0000_0001, 32'h55, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0);

    // Asynchronous reset between edges, request held through the reset edge.
    wr_onehot = '0; rd_req = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd10;
    exp_q.push_back({32'h1, 32'hA5A5_A5A5});
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_rd_valid", {31'd0, rd_valid}, 32'h0);
    check("async_rd_data_a", rd_data_a, 32'h0);
    check("async_rd_data_b", rd_data_b, 32'h0);
    check("async_wr_err", {31'd0, wr_err}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    reset = 1'b0;
    check("post_reset_rd_valid", {31'd0, rd_valid}, 32'h0);
    for (int i = 0; i < 16; i++)
      step(32'h0, 32'h0, 1'b1, 5'(2 * i), 5'(2 * i + 1), 32'h0, 32'h0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_read_mux.md
# regfile_read_mux

Read-side counterpart to the register-file write decoder: a 32-entry register file that accepts a one-hot word-enable vector on its write side and provides two registered 32:1 read ports. Writes are qualified by the one-hot vector produced by the 5-bit write decoder in the datapath. Reads return data one cycle after a request, with same-cycle write forwarding. The block sits between the decode stage (read addresses) and the execute stage (operands) of the CPU.

## Interface
Parameters:
- WIDTH, 32, data width of each register and of both read ports
- ZERO_REG, 1, when 1, register 0 always reads 0 and ignores writes; when 0, register 0 is ordinary storage

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- wr_onehot  input  32  one-hot write-enable; bit i selects register i
- wr_data  input  WIDTH  write data
- rd_req  input  1  read request; both addresses sampled on this edge
- rd_addr_a  input  5  read address, port A
- rd_addr_b  input  5  read address, port B
- rd_data_a  output  WIDTH  registered read data, port A
- rd_data_b  output  WIDTH  registered read data, port B
- rd_valid  output  1  one-cycle pulse; rd_data_a and rd_data_b are valid
- wr_err  output  1  sticky flag; a multi-hot wr_onehot was seen

## Operation
- Storage: 32 x WIDTH flops, all cleared to 0 on reset.
- Write, evaluated on each rising edge:
  - popcount(wr_onehot)==0: no write.
  - popcount==1 at bit i: mem[i] <= wr_data. The write to index 0 is dropped when ZERO_REG=1.
  - popcount>=2: no register is written, and wr_err <= 1.
- wr_err stays set until reset. Nothing else clears it.
- Read, on a rising edge with rd_req=1, for each port p:
  - addr==0 and ZERO_REG=1: rd_data_p <= 0.
  - Else, if the same edge performs a valid single-hot write to addr: rd_data_p <= wr_data (write forwarding).
  - Else: rd_data_p <= mem[addr].
  - rd_valid <= 1.
- Rising edge with rd_req=0: rd_data_a and rd_data_b hold their previous values, and rd_valid <= 0.
- A multi-hot write is never forwarded; a read of an addressed bit returns the old mem contents.
- Both ports may read the same address in the same cycle and return identical data.

## Timing
- Reset (asynchronous assert, synchronous-style release): rd_data_a=0, rd_data_b=0, rd_valid=0, wr_err=0, all mem=0. Reset takes effect immediately and does not wait for clk.
- Reset mid-operation: an in-flight request sampled on the same edge that reset is active is discarded, and rd_valid stays 0.
- Read latency: 1 cycle. A request at edge N produces data and rd_valid=1 after edge N, held until edge N+1.
- Back-to-back requests are allowed every cycle, with no stall and no backpressure.
- Write latency: 1 cycle. A write at edge N is visible to a read at edge N through forwarding, and to any later read from mem.
- wr_err asserts after the edge that sampled the multi-hot vector.
- All outputs come straight from flops. There is no combinational path from any input to any output.

## Test plan
- Reset, then rd_req=1 with rd_addr_a=5 and rd_addr_b=31 -> next cycle rd_data_a=0, rd_data_b=0, rd_valid=1, wr_err=0.
- Write wr_onehot=32'h0000_0020 (reg 5) with wr_data=32'hDEAD_BEEF; next cycle read A=5, B=0 -> rd_data_a=32'hDEAD_BEEF, rd_data_b=0 (ZERO_REG=1). Also write bit 0 with 32'h1234, then read addr 0 -> 0.
- Same-edge forwarding: wr_onehot=32'h0000_0400 (reg 10) with wr_data=32'hA5A5_A5A5, plus rd_req=1 with A=10 and B=10 -> both ports 32'hA5A5_A5A5 after that edge.
- Multi-hot: reg 3 holds 32'h0000_0003; drive wr_onehot=32'h0000_0009 with wr_data=32'hFFFF_FFFF -> wr_err=1, and a later read of reg 3 returns 32'h0000_0003. wr_err remains 1 across 10 further clean writes and clears only on reset.
- Hold behaviour: read reg 5 (32'hDEAD_BEEF), then rd_req=0 for 3 cycles while reg 5 is rewritten to 32'h1 -> rd_valid=0 and rd_data_a stays 32'hDEAD_BEEF for all three cycles.
- Asynchronous reset mid-read: rd_req=1 at edge N, assert reset between edges N and N+1 -> rd_valid and rd_data drop to 0 immediately. After release, reads of all 32 registers return 0.
